bitcoin_mem_responder: RTL and testbench
========================================

Name: bitcoin_mem_responder

Overview:
- Memory-side responder for the bitcoin hash engine's mem_* initiator port.
- Owns the word-addressed 32-bit message/result SRAM and serves engine reads with 1-cycle registered latency and engine writes.
- Gives the host a load/readback port, sequences one hash run (start pulse, completion detect), and counts and checks the result writes landing in the output window.

Parameters:
- ADDR_W, 16, width of all address ports.
- DEPTH, 256, number of implemented 32-bit words; addresses >= DEPTH are out of range.
- OUT_WORDS, 16, result words expected per run.
- TIMEOUT, 4096, maximum RUN cycles before abort.

Ports:
- clk  in  1  single clock for memory, engine and host.
- reset_n  in  1  asynchronous active-low reset.
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data, registered, 1-cycle latency.
- go  in  1  single-cycle request to launch a run.
- cfg_msg_addr  in  ADDR_W  message base address, latched on go.
- cfg_out_addr  in  ADDR_W  output base address, latched on go.
- start  out  1  start pulse to engine.
- message_addr  out  ADDR_W  latched message base, to engine.
- output_addr  out  ADDR_W  latched output base, to engine.
- done  in  1  engine done; may remain high after a run.
- mem_we  in  1  engine write enable.
- mem_addr  in  ADDR_W  engine address.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  engine read data, registered.
- busy  out  1  high in START and RUN.
- results_ready  out  1  high after a successful run.
- err_oob  out  1  sticky out-of-range engine access.
- err_window  out  1  sticky engine write outside the output window.
- err_timeout  out  1  sticky timeout.
- write_count  out  5  distinct in-window writes this run.

Behaviour:
- Reset values: start=0, busy=0, results_ready=0, all err_*=0, write_count=0, message_addr=0, output_addr=0, mem_read_data=0, host_rdata=0, FSM=IDLE. Memory contents are not reset; they keep their values.
- Engine read: every posedge, mem_read_data <= mem[mem_addr], or 0 if mem_addr >= DEPTH. Address presented at edge k gives data valid after edge k+1.
- Host read: the same 1-cycle rule applies to host_addr -> host_rdata, in every state.
- Read-during-write on the same address returns the old data, on both ports.
- Engine writes are accepted only while busy. In IDLE and COMPLETE, engine mem_we is ignored, because the engine leaves mem_we high after finishing.
- Host writes are accepted only when busy=0; host_we while busy is dropped silently.
- Writes to an address >= DEPTH are dropped. An engine access out of range while busy sets err_oob.
- FSM states: IDLE, START, RUN, COMPLETE.
- IDLE: on go, latch cfg_* into message_addr/output_addr, clear write_count, results_ready and err_*, then go to START. go while busy is ignored.
- START: start=1 for exactly one cycle, then go to RUN. The timeout counter clears.
- RUN, distinct-write rule: a cycle counts as a new write when mem_we=1 and (mem_we was 0 last cycle, or mem_addr differs from last cycle's mem_addr). Repeated identical write cycles are not double-counted.
- RUN, in-window write (output_addr <= mem_addr < output_addr+OUT_WORDS, compared in ADDR_W+1 bits so the window does not wrap): write_count increments, saturating at OUT_WORDS.
- RUN, out-of-window write: err_window is set and the write still lands in memory.
- RUN, completion: write_count==OUT_WORDS and done==1 in the same cycle -> COMPLETE, results_ready <= 1. Because completion requires a full count, a done left high from a previous run cannot end the current run early.
- RUN, timeout: counter reaching TIMEOUT -> err_timeout=1 and return to IDLE. results_ready stays 0.
- COMPLETE: busy=0 and results_ready is held. The next go re-enters START directly, clearing status as in IDLE.
- Reset mid-run: FSM returns to IDLE, start=0, all status outputs clear, and any in-flight write is not guaranteed.

Test Plan:
- Host loads words 0..19 at 0x0000 with 0x1000+i, then reads address 5 -> host_rdata=0x00001005 one cycle after the request.
- go with cfg_msg_addr=0, cfg_out_addr=0x0040 -> start high exactly one cycle and busy=1. A behavioural engine reading address 3 at edge k sees 0x00001003 after edge k+1.
- Engine writes 0x0040..0x004F, holding mem_we with the address at 0x004F for 3 extra cycles, then raises done -> write_count=16, results_ready=1, host readback of 0x004F matches the written data.
- Second go with done still high from the first run -> no completion until 16 new writes. Engine write to 0x0030 -> err_window=1.
- Engine never writes and never raises done -> err_timeout=1 after 4096 RUN cycles, FSM in IDLE, results_ready=0.
- Host write during RUN, then reset_n low mid-run -> memory unchanged by the host write, all outputs return to reset values, and a fresh go runs normally.

Source files
------------

// File: rtl/bitcoin_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : bitcoin_mem_responder
// Purpose  : Memory-side responder for the bitcoin hash engine. Owns the
//            word-addressed 32-bit message/result SRAM. Serves engine reads
//            with one cycle of registered latency and accepts engine writes.
//            Gives the host a load/readback port. Sequences one hash run:
//            go -> start pulse -> run -> completion or timeout. Counts and
//            checks the result writes that land in the output window.
// Ports    : clk, reset_n (async, active low)
//            host_we/host_addr/host_wdata/host_rdata : host load/readback
//            go, cfg_msg_addr, cfg_out_addr          : run launch request
//            start, message_addr, output_addr, done  : engine control
//            mem_we/mem_addr/mem_write_data/mem_read_data : engine memory port
//            busy, results_ready, err_oob, err_window, err_timeout,
//            write_count                              : run status
// Revision : 1.0 - initial release
// ============================================================================
module bitcoin_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int OUT_WORDS = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  input  logic              go,
  input  logic [ADDR_W-1:0] cfg_msg_addr,
  input  logic [ADDR_W-1:0] cfg_out_addr,
  output logic              start,
  output logic [ADDR_W-1:0] message_addr,
  output logic [ADDR_W-1:0] output_addr,
  input  logic              done,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_write_data,
  output logic [31:0]       mem_read_data,
  output logic              busy,
  output logic              results_ready,
  output logic              err_oob,
  output logic              err_window,
  output logic              err_timeout,
  output logic [4:0]        write_count
);

  localparam int                  c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  c_TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]     c_DEPTH     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]     c_WIN_SIZE  = (ADDR_W + 1)'(OUT_WORDS);
  localparam logic [4:0]          c_OUT_WORDS = 5'(OUT_WORDS);
  localparam logic [c_TMR_W-1:0]  c_TMR_LAST  = c_TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_START    = 2'd1,
    ST_RUN      = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_start;
  logic                r_busy;
  logic                r_ready;
  logic                r_err_oob;
  logic                r_err_window;
  logic                r_err_timeout;
  logic [4:0]          r_write_count;
  logic [ADDR_W-1:0]   r_message_addr;
  logic [ADDR_W-1:0]   r_output_addr;
  logic [c_TMR_W-1:0]  r_timer;
  logic [31:0]         r_mem_rdata;
  logic [31:0]         r_host_rdata;
  logic                r_prev_we;
  logic [ADDR_W-1:0]   r_prev_addr;

  // Storage is deliberately not reset: host-loaded contents survive a reset.
  logic [31:0]         r_mem [DEPTH];

  logic                w_eng_in_range;
  logic                w_host_in_range;
  logic [ADDR_W:0]     w_win_lo;
  logic [ADDR_W:0]     w_win_hi;
  logic                w_in_window;
  logic                w_new_write;
  logic                w_eng_wr;
  logic                w_host_wr;
  logic                w_wr_en;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [31:0]         w_wr_data;

  assign w_eng_in_range  = {1'b0, mem_addr}  < c_DEPTH;
  assign w_host_in_range = {1'b0, host_addr} < c_DEPTH;

  // Window bounds carry one extra bit so a window near the top of the
  // address space does not wrap around to low addresses.
  assign w_win_lo    = {1'b0, r_output_addr};
  assign w_win_hi    = w_win_lo + c_WIN_SIZE;
  assign w_in_window = ({1'b0, mem_addr} >= w_win_lo) && ({1'b0, mem_addr} < w_win_hi);

  // The engine may hold mem_we on the same address for several cycles; only
  // a rising write strobe or an address change counts as a new result word.
  assign w_new_write = mem_we && (!r_prev_we || (mem_addr != r_prev_addr));

  // Engine and host own the single write port in mutually exclusive phases,
  // so no arbitration is needed.
  assign w_eng_wr  = r_busy  && mem_we  && w_eng_in_range;
  assign w_host_wr = !r_busy && host_we && w_host_in_range;
  assign w_wr_en   = w_eng_wr || w_host_wr;
  assign w_wr_idx  = r_busy ? mem_addr[c_IDX_W-1:0] : host_addr[c_IDX_W-1:0];
  assign w_wr_data = r_busy ? mem_write_data : host_wdata;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  // Registered reads sample the array before this edge's write lands, so a
  // read of the address being written returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_rdata  <= '0;
      r_host_rdata <= '0;
      r_prev_we    <= 1'b0;
      r_prev_addr  <= '0;
    end else begin
      r_mem_rdata  <= w_eng_in_range  ? r_mem[mem_addr[c_IDX_W-1:0]]  : '0;
      r_host_rdata <= w_host_in_range ? r_mem[host_addr[c_IDX_W-1:0]] : '0;
      r_prev_we    <= mem_we;
      r_prev_addr  <= mem_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_ready        <= 1'b0;
      r_err_oob      <= 1'b0;
      r_err_window   <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_write_count  <= '0;
      r_message_addr <= '0;
      r_output_addr  <= '0;
      r_timer        <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_COMPLETE: begin
          if (go) begin
            r_message_addr <= cfg_msg_addr;
            r_output_addr  <= cfg_out_addr;
            r_write_count  <= '0;
            r_ready        <= 1'b0;
            r_err_oob      <= 1'b0;
            r_err_window   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_start        <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= ST_START;
          end
        end
        ST_START: begin
          r_start <= 1'b0;
          r_timer <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_new_write && w_in_window && (r_write_count != c_OUT_WORDS)) begin
            r_write_count <= r_write_count + 5'd1;
          end
          if (mem_we && !w_in_window) begin
            r_err_window <= 1'b1;
          end
          // Requiring a full count means a done level left over from an
          // earlier run cannot terminate this one.
          if ((r_write_count == c_OUT_WORDS) && done) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_COMPLETE;
          end else if (r_timer == c_TMR_LAST) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // r_busy is low on the go edge, so this never fights the clear above.
      if (r_busy && !w_eng_in_range) begin
        r_err_oob <= 1'b1;
      end
    end
  end

  assign host_rdata    = r_host_rdata;
  assign mem_read_data = r_mem_rdata;
  assign start         = r_start;
  assign busy          = r_busy;
  assign results_ready = r_ready;
  assign err_oob       = r_err_oob;
  assign err_window    = r_err_window;
  assign err_timeout   = r_err_timeout;
  assign write_count   = r_write_count;
  assign message_addr  = r_message_addr;
  assign output_addr   = r_output_addr;

endmodule
`default_nettype wire

// File: tb/tb_bitcoin_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitcoin_mem_responder
// Purpose  : Self-checking bench for bitcoin_mem_responder. A behavioural
//            engine/host drive the DUT; a cycle-level reference model of the
//            responder's documented rules supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitcoin_mem_responder;

  localparam int ADDR_W    = 16;
  localparam int DEPTH     = 256;
  localparam int OUT_WORDS = 16;
  localparam int TIMEOUT   = 4096;

  localparam int S_IDLE     = 0;
  localparam int S_START    = 1;
  localparam int S_RUN      = 2;
  localparam int S_COMPLETE = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              go;
  logic [ADDR_W-1:0] cfg_msg_addr;
  logic [ADDR_W-1:0] cfg_out_addr;
  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [ADDR_W-1:0] output_addr;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              busy;
  logic              results_ready;
  logic              err_oob;
  logic              err_window;
  logic              err_timeout;
  logic [4:0]        write_count;

  always #5 clk = ~clk;

  bitcoin_mem_responder #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUT_WORDS(OUT_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .go(go), .cfg_msg_addr(cfg_msg_addr), .cfg_out_addr(cfg_out_addr),
    .start(start), .message_addr(message_addr), .output_addr(output_addr), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy), .results_ready(results_ready),
    .err_oob(err_oob), .err_window(err_window), .err_timeout(err_timeout),
    .write_count(write_count)
  );

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  bit          m_known   [DEPTH];
  int          m_state, m_timer, m_cnt, m_prev_addr, m_msg, m_out;
  bit          m_start, m_ready, m_oob, m_win, m_to, m_prev_we;
  logic [31:0] m_mrd, m_hrd;
  bit          m_mrd_k, m_hrd_k;

  int vectors     = 0;
  int miscompares = 0;

  logic [10:0] dut_status;
  assign dut_status = {start, busy, results_ready, err_oob, err_window, err_timeout, write_count};

  function automatic logic [10:0] exp_status();
    return {m_start, (m_state == S_START || m_state == S_RUN), m_ready, m_oob, m_win, m_to, 5'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_timer = 0; m_cnt = 0; m_prev_addr = 0; m_msg = 0; m_out = 0;
    m_start = 0; m_ready = 0; m_oob = 0; m_win = 0; m_to = 0; m_prev_we = 0;
    m_mrd = 0; m_hrd = 0; m_mrd_k = 1; m_hrd_k = 1;
  endtask

  // Advance one clock; inputs are stable across the edge, so the model reads
  // them after the edge and commits the documented next-state rules.
  task automatic step();
    int ea, ha, old_cnt;
    bit busy_now, in_win, new_wr;
    @(posedge clk);
    ea       = int'(mem_addr);
    ha       = int'(host_addr);
    busy_now = (m_state == S_START) || (m_state == S_RUN);
    in_win   = (ea >= m_out) && (ea < m_out + OUT_WORDS);
    new_wr   = mem_we && (!m_prev_we || ea != m_prev_addr);
    old_cnt  = m_cnt;
    if (ea < DEPTH) begin m_mrd = model_mem[ea]; m_mrd_k = m_known[ea]; end
    else begin m_mrd = 32'h0; m_mrd_k = 1; end
    if (ha < DEPTH) begin m_hrd = model_mem[ha]; m_hrd_k = m_known[ha]; end
    else begin m_hrd = 32'h0; m_hrd_k = 1; end
    if (busy_now) begin
      if (mem_we && ea < DEPTH) begin model_mem[ea] = mem_write_data; m_known[ea] = 1; end
    end else if (host_we && ha < DEPTH) begin
      model_mem[ha] = host_wdata; m_known[ha] = 1;
    end
    if (busy_now && ea >= DEPTH) m_oob = 1;
    if (m_state == S_IDLE || m_state == S_COMPLETE) begin
      if (go) begin
        m_state = S_START; m_start = 1; m_msg = int'(cfg_msg_addr); m_out = int'(cfg_out_addr);
        m_cnt = 0; m_ready = 0; m_oob = 0; m_win = 0; m_to = 0;
      end
    end else if (m_state == S_START) begin
      m_start = 0; m_timer = 0; m_state = S_RUN;
    end else begin
      if (mem_we && !in_win) m_win = 1;
      if (new_wr && in_win && m_cnt < OUT_WORDS) m_cnt = m_cnt + 1;
      if (old_cnt == OUT_WORDS && done) begin m_state = S_COMPLETE; m_ready = 1; end
      else if (m_timer + 1 == TIMEOUT) begin m_to = 1; m_state = S_IDLE; end
      else m_timer = m_timer + 1;
    end
    m_prev_we   = mem_we;
    m_prev_addr = ea;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 0; host_we = 0; host_addr = 0; host_wdata = 0; go = 0;
    cfg_msg_addr = 0; cfg_out_addr = 0; done = 0; mem_we = 0; mem_addr = 0; mem_write_data = 0;
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = 32'h0; m_known[i] = 0; end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (dut_status !== 11'd0) begin miscompares++; $display("FAIL reset_status: got %b want %b", dut_status, 11'd0); end
    vectors++;
    if ({message_addr, output_addr} !== 32'h0) begin miscompares++; $display("FAIL reset_addrs: got %h want 0", {message_addr, output_addr}); end
    vectors++;
    if ({mem_read_data, host_rdata} !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", {mem_read_data, host_rdata}); end
    reset_n = 1;
  endtask

  task automatic test_host_port();
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      host_we = 1; host_addr = ADDR_W'(i); host_wdata = 32'h1000 + 32'(i); step();
    end
    host_we = 0; host_addr = 16'd5; step();
    vectors++;
    if (host_rdata !== 32'h0000_1005) begin miscompares++; $display("FAIL host_read5: got %h want %h", host_rdata, 32'h1005); end
    // read-during-write returns the old word
    d = $urandom; host_we = 1; host_addr = 16'd21; host_wdata = d; step();
    host_wdata = ~d; step();
    vectors++;
    if (host_rdata !== d) begin miscompares++; $display("FAIL host_rdw: got %h want %h", host_rdata, d); end
    host_we = 0; step();
    vectors++;
    if (host_rdata !== ~d) begin miscompares++; $display("FAIL host_after_rdw: got %h want %h", host_rdata, ~d); end
    // random host traffic; engine strobes in IDLE must be ignored
    for (int i = 0; i < 80; i++) begin
      host_we = 1'($urandom); host_addr = ADDR_W'($urandom_range(20, DEPTH + 7));
      host_wdata = $urandom; mem_we = 1'($urandom);
      mem_addr = ADDR_W'($urandom_range(0, DEPTH + 7)); mem_write_data = $urandom;
      step();
      if (m_hrd_k) begin
        vectors++;
        if (host_rdata !== m_hrd) begin miscompares++; $display("FAIL rand_host_rd[%0d]: got %h want %h", i, host_rdata, m_hrd); end
      end
      if (m_mrd_k) begin
        vectors++;
        if (mem_read_data !== m_mrd) begin miscompares++; $display("FAIL rand_mem_rd[%0d]: got %h want %h", i, mem_read_data, m_mrd); end
      end
      vectors++;
      if (dut_status !== exp_status()) begin miscompares++; $display("FAIL rand_idle_status[%0d]: got %b want %b", i, dut_status, exp_status()); end
    end
    host_we = 0; mem_we = 0; mem_addr = 0;
  endtask

  task automatic test_run_complete();
    logic [31:0] wd [OUT_WORDS];
    go = 1; cfg_msg_addr = 16'h0000; cfg_out_addr = 16'h0040; step(); go = 0;
    vectors++;
    if ({start, busy} !== 2'b11) begin miscompares++; $display("FAIL go_start_busy: got %b want 11", {start, busy}); end
    vectors++;
    if ({message_addr, output_addr} !== {16'h0000, 16'h0040}) begin miscompares++; $display("FAIL go_addrs: got %h want 00000040", {message_addr, output_addr}); end
    mem_addr = 16'd3; step();
    vectors++;
    if ({start, busy} !== 2'b01) begin miscompares++; $display("FAIL start_one_cycle: got %b want 01", {start, busy}); end
    vectors++;
    if (mem_read_data !== 32'h0000_1003) begin miscompares++; $display("FAIL eng_read3: got %h want %h", mem_read_data, 32'h1003); end
    for (int i = 0; i < OUT_WORDS; i++) begin
      wd[i] = $urandom; mem_we = 1; mem_addr = 16'h0040 + ADDR_W'(i); mem_write_data = wd[i]; step();
    end
    repeat (3) step();
    vectors++;
    if (write_count !== 5'd16 || dut_status !== exp_status()) begin miscompares++; $display("FAIL count_full: got %b want %b", dut_status, exp_status()); end
    done = 1; step();
    vectors++;
    if ({busy, results_ready} !== 2'b01 || dut_status !== exp_status()) begin miscompares++; $display("FAIL complete: got %b want %b", dut_status, exp_status()); end
    // engine leaves mem_we high after finishing; it must not corrupt results
    mem_write_data = ~wd[15]; step();
    host_addr = 16'h004F; step();
    vectors++;
    if (host_rdata !== wd[15]) begin miscompares++; $display("FAIL readback_4f: got %h want %h", host_rdata, wd[15]); end
    vectors++;
    if (mem_read_data !== wd[15]) begin miscompares++; $display("FAIL eng_read_4f: got %h want %h", mem_read_data, wd[15]); end
  endtask

  task automatic test_rerun_done_high();
    int perm [OUT_WORDS];
    int j, t;
    for (int i = 0; i < OUT_WORDS; i++) perm[i] = i;
    for (int i = OUT_WORDS - 1; i > 0; i--) begin
      j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    go = 1; cfg_out_addr = 16'h0040; step(); go = 0;
    vectors++;
    if ({results_ready, write_count} !== 6'd0 || dut_status !== exp_status()) begin miscompares++; $display("FAIL rerun_clear: got %b want %b", dut_status, exp_status()); end
    step();
    mem_addr = 16'h0030; mem_write_data = $urandom; step();
    mem_addr = 16'h0100; mem_write_data = $urandom; step();
    vectors++;
    if ({err_oob, err_window} !== 2'b11 || dut_status !== exp_status()) begin miscompares++; $display("FAIL rerun_errs: got %b want %b", dut_status, exp_status()); end
    vectors++;
    if (mem_read_data !== 32'h0) begin miscompares++; $display("FAIL oob_read: got %h want 0", mem_read_data); end
    for (int i = 0; i < OUT_WORDS; i++) begin
      mem_addr = 16'h0040 + ADDR_W'(perm[i]); mem_write_data = $urandom; step();
      vectors++;
      if (dut_status !== exp_status()) begin miscompares++; $display("FAIL rerun_w[%0d]: got %b want %b", i, dut_status, exp_status()); end
      if (i == OUT_WORDS - 2) begin
        vectors++;
        if ({busy, results_ready} !== 2'b10) begin miscompares++; $display("FAIL stale_done: got %b want 10", {busy, results_ready}); end
      end
    end
    step();
    vectors++;
    if ({busy, results_ready} !== 2'b01 || dut_status !== exp_status()) begin miscompares++; $display("FAIL rerun_complete: got %b want %b", dut_status, exp_status()); end
    for (int i = 0; i < 6; i++) begin
      host_addr = (i == 0) ? 16'h0030 : 16'h0040 + ADDR_W'($urandom_range(0, OUT_WORDS - 1)); step();
      vectors++;
      if (host_rdata !== m_hrd) begin miscompares++; $display("FAIL rerun_rb[%0d]: got %h want %h", i, host_rdata, m_hrd); end
    end
  endtask

  task automatic test_timeout();
    int n;
    mem_we = 0; done = 0; mem_addr = 0;
    go = 1; cfg_out_addr = 16'h0060; step(); go = 0;
    n = 0;
    while (busy === 1'b1 && n < TIMEOUT + 100) begin n++; step(); end
    vectors++;
    if (n !== TIMEOUT + 1) begin miscompares++; $display("FAIL timeout_len: got %0d want %0d busy cycles", n, TIMEOUT + 1); end
    vectors++;
    if (dut_status !== exp_status() || {err_timeout, results_ready, busy} !== 3'b100) begin miscompares++; $display("FAIL timeout_status: got %b want %b", dut_status, exp_status()); end
  endtask

  task automatic test_reset_midrun();
    go = 1; cfg_out_addr = 16'h0080; step(); go = 0; step();
    host_we = 1; host_addr = 16'd10; host_wdata = 32'hDEAD_BEEF; step(); host_we = 0;
    mem_we = 1; mem_addr = 16'h0080; mem_write_data = $urandom; step();
    mem_addr = 16'h0081; mem_write_data = $urandom; step();
    vectors++;
    if (host_rdata !== 32'h0000_100A) begin miscompares++; $display("FAIL host_wr_busy: got %h want %h", host_rdata, 32'h100A); end
    vectors++;
    if (dut_status !== exp_status()) begin miscompares++; $display("FAIL midrun: got %b want %b", dut_status, exp_status()); end
    mem_we = 0; reset_n = 0; #1;
    model_reset();
    vectors++;
    if (dut_status !== 11'd0 || {message_addr, output_addr} !== 32'h0) begin miscompares++; $display("FAIL async_reset: got %b want 0", dut_status); end
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
    host_addr = 16'd10; step();
    vectors++;
    if (host_rdata !== 32'h0000_100A) begin miscompares++; $display("FAIL mem_kept: got %h want %h", host_rdata, 32'h100A); end
    go = 1; cfg_out_addr = 16'h0090; step(); go = 0; step();
    mem_we = 1;
    for (int i = 0; i < OUT_WORDS; i++) begin
      mem_addr = 16'h0090 + ADDR_W'(i); mem_write_data = $urandom; step();
    end
    mem_we = 0; done = 1; step();
    vectors++;
    if (results_ready !== 1'b1 || dut_status !== exp_status()) begin miscompares++; $display("FAIL fresh_run: got %b want %b", dut_status, exp_status()); end
    host_addr = 16'h0090 + ADDR_W'($urandom_range(0, OUT_WORDS - 1)); step();
    vectors++;
    if (host_rdata !== m_hrd) begin miscompares++; $display("FAIL fresh_rb: got %h want %h", host_rdata, m_hrd); end
  endtask

  initial begin
    test_reset();
    test_host_port();
    test_run_complete();
    test_rerun_done_high();
    test_timeout();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
